// File: rtl/param_regbank_nch.sv
// Per-channel DDS parameter bank: a host (id, value) write stream fills shadow sets,
// and commit or auto-commit copies them into the active sets that drive the channel cores.
module param_regbank_nch #(
  parameter int unsigned NUM_CH       = 2,
  parameter logic [31:0] FREQ_DEFAULT = 32'd343597
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [7:0]             wr_id,
  input  logic [31:0]            wr_value,
  input  logic                   rd_en,
  input  logic [7:0]             rd_id,
  output logic                   rd_valid,
  output logic [31:0]            rd_data,
  output logic [32*NUM_CH-1:0]   freq,
  output logic [14*NUM_CH-1:0]   phase,
  output logic [5*NUM_CH-1:0]    amp,
  output logic [3*NUM_CH-1:0]    wave,
  output logic [14*NUM_CH-1:0]   bias,
  output logic [NUM_CH-1:0]      upd,
  output logic                   err
);

  localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [7:0] ID_FREQ   = 8'h01;
  localparam logic [7:0] ID_PHASE  = 8'h02;
  localparam logic [7:0] ID_WAVE   = 8'h03;
  localparam logic [7:0] ID_AMP    = 8'h04;
  localparam logic [7:0] ID_SEL    = 8'h05;
  localparam logic [7:0] ID_BIAS   = 8'h07;
  localparam logic [7:0] ID_COMMIT = 8'h0B;
  localparam logic [7:0] ID_AUTO   = 8'h0C;
  localparam logic [7:0] ID_ERRCLR = 8'h0F;

  logic [31:0]       r_sh_freq   [NUM_CH];
  logic [13:0]       r_sh_phase  [NUM_CH];
  logic [2:0]        r_sh_wave   [NUM_CH];
  logic [4:0]        r_sh_amp    [NUM_CH];
  logic [13:0]       r_sh_bias   [NUM_CH];
  logic [31:0]       r_act_freq  [NUM_CH];
  logic [13:0]       r_act_phase [NUM_CH];
  logic [2:0]        r_act_wave  [NUM_CH];
  logic [4:0]        r_act_amp   [NUM_CH];
  logic [13:0]       r_act_bias  [NUM_CH];

  logic [SEL_W-1:0]  r_sel;
  logic              r_auto;
  logic              r_err;
  logic [NUM_CH-1:0] r_upd;
  logic              r_rd_valid;
  logic [31:0]       r_rd_data;

  logic              w_fld_wr;
  logic              w_sel_wr;
  logic              w_sel_bad;
  logic              w_cmt_wr;
  logic              w_auto_wr;
  logic              w_clr_wr;
  logic              w_bad_id;
  logic [NUM_CH-1:0] w_tgt;
  logic [NUM_CH-1:0] w_cmt_mask;
  logic [NUM_CH-1:0] w_upd_nxt;
  logic [31:0]       w_sel_freq;
  logic [13:0]       w_sel_phase;
  logic [2:0]        w_sel_wave;
  logic [4:0]        w_sel_amp;
  logic [13:0]       w_sel_bias;
  logic [31:0]       w_rd_mux;

  // Classify the incoming write by parameter ID.
  always_comb begin
    w_fld_wr  = 1'b0;
    w_sel_wr  = 1'b0;
    w_cmt_wr  = 1'b0;
    w_auto_wr = 1'b0;
    w_clr_wr  = 1'b0;
    w_bad_id  = 1'b0;
    if (wr_en) begin
      case (wr_id)
        ID_FREQ, ID_PHASE, ID_WAVE, ID_AMP, ID_BIAS: w_fld_wr = 1'b1;
        ID_SEL:    w_sel_wr  = 1'b1;
        ID_COMMIT: w_cmt_wr  = 1'b1;
        ID_AUTO:   w_auto_wr = 1'b1;
        ID_ERRCLR: w_clr_wr  = 1'b1;
        default:   w_bad_id  = 1'b1;
      endcase
    end else begin
      w_bad_id = 1'b0;
    end
  end

  assign w_sel_bad = w_sel_wr && (wr_value >= 32'(NUM_CH));

  // Per-channel write target, commit mask and update pulses for the next cycle.
  always_comb begin
    w_tgt      = '0;
    w_cmt_mask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_fld_wr && (r_sel == SEL_W'(i))) begin
        w_tgt[i] = 1'b1;
      end else begin
        w_tgt[i] = 1'b0;
      end
      if (w_cmt_wr) begin
        w_cmt_mask[i] = wr_value[i];
      end else begin
        w_cmt_mask[i] = 1'b0;
      end
    end
    if (r_auto) begin
      w_upd_nxt = w_cmt_mask | w_tgt;
    end else begin
      w_upd_nxt = w_cmt_mask;
    end
  end

  // Shadow and active register sets; a commit copies the whole shadow set atomically.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (!rst_n) begin
        r_sh_freq[i]   <= FREQ_DEFAULT;
        r_sh_phase[i]  <= 14'd0;
        r_sh_wave[i]   <= 3'd0;
        r_sh_amp[i]    <= 5'd0;
        r_sh_bias[i]   <= 14'd0;
        r_act_freq[i]  <= FREQ_DEFAULT;
        r_act_phase[i] <= 14'd0;
        r_act_wave[i]  <= 3'd0;
        r_act_amp[i]   <= 5'd0;
        r_act_bias[i]  <= 14'd0;
      end else begin
        if (w_tgt[i]) begin
          case (wr_id)
            ID_FREQ:  r_sh_freq[i]  <= wr_value;
            ID_PHASE: r_sh_phase[i] <= wr_value[13:0];
            ID_WAVE:  r_sh_wave[i]  <= wr_value[2:0];
            ID_AMP:   r_sh_amp[i]   <= wr_value[4:0];
            ID_BIAS:  r_sh_bias[i]  <= wr_value[13:0];
            default:  r_sh_freq[i]  <= r_sh_freq[i];
          endcase
        end
        if (w_cmt_mask[i]) begin
          r_act_freq[i]  <= r_sh_freq[i];
          r_act_phase[i] <= r_sh_phase[i];
          r_act_wave[i]  <= r_sh_wave[i];
          r_act_amp[i]   <= r_sh_amp[i];
          r_act_bias[i]  <= r_sh_bias[i];
        end else if (w_tgt[i] && r_auto) begin
          case (wr_id)
            ID_FREQ:  r_act_freq[i]  <= wr_value;
            ID_PHASE: r_act_phase[i] <= wr_value[13:0];
            ID_WAVE:  r_act_wave[i]  <= wr_value[2:0];
            ID_AMP:   r_act_amp[i]   <= wr_value[4:0];
            ID_BIAS:  r_act_bias[i]  <= wr_value[13:0];
            default:  r_act_freq[i]  <= r_act_freq[i];
          endcase
        end
      end
    end
  end

  // Channel select, auto-commit mode, sticky error and update pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sel  <= '0;
      r_auto <= 1'b0;
      r_err  <= 1'b0;
      r_upd  <= '0;
    end else begin
      r_upd <= w_upd_nxt;
      if (w_sel_wr && !w_sel_bad) begin
        r_sel <= wr_value[SEL_W-1:0];
      end
      if (w_auto_wr) begin
        r_auto <= wr_value[0];
      end
      if (w_clr_wr) begin
        r_err <= 1'b0;
      end else if (w_sel_bad || w_bad_id) begin
        r_err <= 1'b1;
      end
    end
  end

  // Shadow fields of the selected channel, as seen by readback.
  always_comb begin
    w_sel_freq  = 32'd0;
    w_sel_phase = 14'd0;
    w_sel_wave  = 3'd0;
    w_sel_amp   = 5'd0;
    w_sel_bias  = 14'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_sel == SEL_W'(i)) begin
        w_sel_freq  = r_sh_freq[i];
        w_sel_phase = r_sh_phase[i];
        w_sel_wave  = r_sh_wave[i];
        w_sel_amp   = r_sh_amp[i];
        w_sel_bias  = r_sh_bias[i];
      end else begin
        w_sel_freq = w_sel_freq;
      end
    end
  end

  // Readback mux works on pre-write state, so a same-cycle write is not visible.
  always_comb begin
    w_rd_mux = 32'd0;
    case (rd_id)
      ID_FREQ:   w_rd_mux = w_sel_freq;
      ID_PHASE:  w_rd_mux = {18'd0, w_sel_phase};
      ID_WAVE:   w_rd_mux = {29'd0, w_sel_wave};
      ID_AMP:    w_rd_mux = {27'd0, w_sel_amp};
      ID_BIAS:   w_rd_mux = {18'd0, w_sel_bias};
      ID_SEL:    w_rd_mux = 32'(r_sel);
      ID_AUTO:   w_rd_mux = {31'd0, r_auto};
      ID_ERRCLR: w_rd_mux = {31'd0, r_err};
      default:   w_rd_mux = 32'd0;
    endcase
  end

  // Readback response register: one valid cycle per request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= 32'd0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_rd_data <= w_rd_mux;
      end else begin
        r_rd_data <= 32'd0;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign freq[32*g +: 32]  = r_act_freq[g];
    assign phase[14*g +: 14] = r_act_phase[g];
    assign wave[3*g +: 3]    = r_act_wave[g];
    assign amp[5*g +: 5]     = r_act_amp[g];
    assign bias[14*g +: 14]  = r_act_bias[g];
  end

  assign upd      = r_upd;
  assign err      = r_err;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_param_regbank_nch.sv
// Bench for param_regbank_nch: directed pinning sequence, then random traffic against
// a table-driven model of the shadow/active parameter sets.
module tb_param_regbank_nch;

  localparam int unsigned NUM_CH       = 2;
  localparam logic [31:0] FREQ_DEFAULT = 32'd343597;
  localparam logic [31:0] FMASK [5] = '{32'hFFFF_FFFF, 32'h0000_3FFF, 32'h0000_0007,
                                        32'h0000_001F, 32'h0000_3FFF};

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 wr_en = 1'b0;
  logic [7:0]           wr_id = 8'd0;
  logic [31:0]          wr_value = 32'd0;
  logic                 rd_en = 1'b0;
  logic [7:0]           rd_id = 8'd0;
  logic                 rd_valid;
  logic [31:0]          rd_data;
  logic [32*NUM_CH-1:0] freq;
  logic [14*NUM_CH-1:0] phase;
  logic [5*NUM_CH-1:0]  amp;
  logic [3*NUM_CH-1:0]  wave;
  logic [14*NUM_CH-1:0] bias;
  logic [NUM_CH-1:0]    upd;
  logic                 err;

  int checks = 0;
  int failures = 0;

  param_regbank_nch #(.NUM_CH(NUM_CH), .FREQ_DEFAULT(FREQ_DEFAULT)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_id(wr_id), .wr_value(wr_value),
    .rd_en(rd_en), .rd_id(rd_id), .rd_valid(rd_valid), .rd_data(rd_data),
    .freq(freq), .phase(phase), .amp(amp), .wave(wave), .bias(bias),
    .upd(upd), .err(err)
  );

  always #5 clk = ~clk;

  // Model state: fields indexed 0..4 = freq, phase, wave, amp, bias.
  logic [31:0]       m_sh  [NUM_CH][5];
  logic [31:0]       m_act [NUM_CH][5];
  int                m_sel;
  bit                m_auto;
  bit                m_err;
  logic [NUM_CH-1:0] m_upd;
  bit                m_rv;
  logic [31:0]       m_rd;
  bit                m_live = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int fidx(input logic [7:0] id);
    case (id)
      8'h01: return 0;
      8'h02: return 1;
      8'h03: return 2;
      8'h04: return 3;
      8'h07: return 4;
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] id);
    int f;
    f = fidx(id);
    if (f >= 0) return m_sh[m_sel][f];
    case (id)
      8'h05: return 32'(m_sel);
      8'h0C: return {31'd0, m_auto};
      8'h0F: return {31'd0, m_err};
      default: return 32'd0;
    endcase
  endfunction

  // Reference model: advances on every rising edge from the values the DUT samples.
  always @(posedge clk) begin : model
    int f;
    m_live = 1'b1;
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int k = 0; k < 5; k++) begin
          m_sh[c][k]  = (k == 0) ? FREQ_DEFAULT : 32'd0;
          m_act[c][k] = (k == 0) ? FREQ_DEFAULT : 32'd0;
        end
      end
      m_sel = 0; m_auto = 1'b0; m_err = 1'b0;
      m_upd = '0; m_rv = 1'b0; m_rd = 32'd0;
    end else begin
      m_rv  = rd_en;
      m_rd  = rd_en ? model_read(rd_id) : 32'd0;
      m_upd = '0;
      if (wr_en) begin
        f = fidx(wr_id);
        if (f >= 0) begin
          m_sh[m_sel][f] = wr_value & FMASK[f];
          if (m_auto) begin
            m_act[m_sel][f] = m_sh[m_sel][f];
            m_upd[m_sel] = 1'b1;
          end
        end else begin
          case (wr_id)
            8'h05: if (wr_value < 32'(NUM_CH)) m_sel = int'(wr_value); else m_err = 1'b1;
            8'h0B: begin
              for (int c = 0; c < NUM_CH; c++) begin
                if (wr_value[c]) begin
                  for (int k = 0; k < 5; k++) m_act[c][k] = m_sh[c][k];
                  m_upd[c] = 1'b1;
                end
              end
            end
            8'h0C: m_auto = wr_value[0];
            8'h0F: m_err = 1'b0;
            default: m_err = 1'b1;
          endcase
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin : compare
    logic [32*NUM_CH-1:0] ef;
    logic [14*NUM_CH-1:0] ep, eb;
    logic [5*NUM_CH-1:0]  ea;
    logic [3*NUM_CH-1:0]  ew;
    if (m_live) begin
      for (int c = 0; c < NUM_CH; c++) begin
        ef[32*c +: 32] = m_act[c][0];
        ep[14*c +: 14] = m_act[c][1][13:0];
        ew[3*c +: 3]   = m_act[c][2][2:0];
        ea[5*c +: 5]   = m_act[c][3][4:0];
        eb[14*c +: 14] = m_act[c][4][13:0];
      end
      chk("freq", 64'(freq), 64'(ef));
      chk("phase", 64'(phase), 64'(ep));
      chk("wave", 64'(wave), 64'(ew));
      chk("amp", 64'(amp), 64'(ea));
      chk("bias", 64'(bias), 64'(eb));
      chk("upd", 64'(upd), 64'(m_upd));
      chk("err", 64'(err), 64'(m_err));
      chk("rd_valid", 64'(rd_valid), 64'(m_rv));
      if (m_rv) chk("rd_data", 64'(rd_data), 64'(m_rd));
    end
  end

  task automatic cyc(input bit rst, input bit we, input logic [7:0] wid, input logic [31:0] wv,
                     input bit re, input logic [7:0] rid);
    @(negedge clk);
    rst_n = rst; wr_en = we; wr_id = wid; wr_value = wv; rd_en = re; rd_id = rid;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic wr(input logic [7:0] wid, input logic [31:0] wv);
    cyc(1'b1, 1'b1, wid, wv, 1'b0, 8'd0);
  endtask

  task automatic rd(input logic [7:0] rid);
    cyc(1'b1, 1'b0, 8'd0, 32'd0, 1'b1, rid);
  endtask

  localparam logic [7:0] IDS [12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h07,
                                      8'h0B, 8'h0C, 8'h0F, 8'h00, 8'h44, 8'hFF};

  initial begin
    logic [7:0]  wid, rid;
    logic [31:0] wv;
    cyc(1'b0, 1'b0, 8'd0, 32'd0, 1'b0, 8'd0);
    cyc(1'b0, 1'b0, 8'd0, 32'd0, 1'b0, 8'd0);
    chk("rst_freq", 64'(freq), {32'd343597, 32'd343597});
    chk("rst_upd", 64'(upd), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);

    rd(8'h01);
    chk("rd_freq_default", 64'(rd_data), 64'd343597);
    chk("rd_valid_pulse", 64'(rd_valid), 64'd1);

    wr(8'h05, 32'd1);
    wr(8'h01, 32'd1000);
    chk("shadow_not_active", 64'(freq), {32'd343597, 32'd343597});
    wr(8'h0B, 32'b10);
    chk("commit_freq", 64'(freq), {32'd1000, 32'd343597});
    chk("commit_upd", 64'(upd), 64'b10);
    rd(8'h00);
    chk("upd_one_cycle", 64'(upd), 64'd0);

    wr(8'h05, 32'd0);
    wr(8'h0C, 32'd1);
    wr(8'h02, 32'h3FFF);
    chk("auto_phase", 64'(phase[13:0]), 64'h3FFF);
    chk("auto_upd", 64'(upd), 64'b01);
    wr(8'h02, 32'h12345);
    chk("phase_trunc", 64'(phase[13:0]), 64'h2345);
    wr(8'h02, 32'h1FFFF);
    chk("phase_trunc_max", 64'(phase[13:0]), 64'h3FFF);

    wr(8'h05, 32'd5);
    chk("bad_sel_err", 64'(err), 64'd1);
    rd(8'h05);
    chk("bad_sel_kept", 64'(rd_data), 64'd0);
    wr(8'h44, 32'd0);
    chk("bad_id_err", 64'(err), 64'd1);
    wr(8'h0F, 32'd0);
    chk("err_clear", 64'(err), 64'd0);
    rd(8'h44);
    chk("rd_unknown", 64'(rd_data), 64'd0);
    chk("rd_unknown_err", 64'(err), 64'd0);

    wr(8'h04, 32'd3);
    cyc(1'b1, 1'b1, 8'h04, 32'd7, 1'b1, 8'h04);
    chk("rd_prewrite", 64'(rd_data), 64'd3);
    rd(8'h04);
    chk("rd_postwrite", 64'(rd_data), 64'd7);

    wr(8'h0B, 32'b11);
    cyc(1'b0, 1'b1, 8'h01, 32'd55, 1'b1, 8'h01);
    chk("rst_cancel_upd", 64'(upd), 64'd0);
    chk("rst_cancel_rv", 64'(rd_valid), 64'd0);
    chk("rst_amp", 64'(amp), 64'd0);
    chk("rst_freq2", 64'(freq), {32'd343597, 32'd343597});
    rd(8'h04);
    chk("rst_shadow_amp", 64'(rd_data), 64'd0);

    for (int n = 0; n < 3000; n++) begin
      wid = IDS[$urandom_range(0, 11)];
      rid = IDS[$urandom_range(0, 11)];
      case (wid)
        8'h05:   wv = 32'($urandom_range(0, 3));
        8'h0B:   wv = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        default: wv = $urandom;
      endcase
      cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), wid, wv,
          ($urandom_range(0, 1) != 0), rid);
    end

    cyc(1'b1, 1'b0, 8'd0, 32'd0, 1'b0, 8'd0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_regbank_nch.md
# param_regbank_nch

Clocked, parametrised successor to the combinational parameter decoder: accepts the host's (parameter_id, parameter_value) write stream and maintains per-channel signal-generator parameters for NUM_CH channels. Each channel has a shadow register set and an active register set; a commit or auto-commit mode moves shadow values to active so that a channel never runs with a half-updated configuration. Sits between the host register interface and the DDS channel cores, and adds readback and sticky error reporting.

## Interface
- NUM_CH, 2, number of DDS channels (2..8)
- FREQ_DEFAULT, 32'd343597, reset frequency word for every channel (10 kHz)
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- wr_en  in  1  write strobe; one write is accepted per cycle, always ready
- wr_id  in  8  parameter ID
- wr_value  in  32  parameter value
- rd_en  in  1  readback request
- rd_id  in  8  readback parameter ID
- rd_valid  out  1  readback data valid
- rd_data  out  32  readback data, zero-extended
- freq  out  32*NUM_CH  active frequency words; channel i at [32i+31:32i]
- phase  out  14*NUM_CH  active phase offsets
- amp  out  5*NUM_CH  active amplitude codes
- wave  out  3*NUM_CH  active wave types
- bias  out  14*NUM_CH  active voltage biases
- upd  out  NUM_CH  one-cycle pulse per channel whose active set changed
- err  out  1  sticky error flag

## Operation
- ID map:
  - 0x01 freq, 0x02 phase, 0x03 wave, 0x04 amp, 0x07 bias: write the shadow of the selected channel; truncate the value to the field width (LSBs).
  - 0x05 channel select: sel <= value[clog2(NUM_CH)-1:0]. If value >= NUM_CH, sel is unchanged and err is set.
  - 0x0B commit: for each bit i < NUM_CH set in value[NUM_CH-1:0], active[i] <= shadow[i]. Bits at or above NUM_CH are ignored.
  - 0x0C auto-commit: auto <= value[0].
  - 0x0F: clears err.
  - Any other ID: no state change, err set.
- When auto=1, a field write updates the shadow and the active register of sel in the same edge, and pulses upd[sel].
- upd[i] fires on a commit or auto write even if the value is unchanged.
- A commit also pulses upd for every masked channel; a mask of 0 produces no pulse.
- Readback:
  - Field IDs return the shadow of sel.
  - 0x05 returns sel; 0x0C returns auto; 0x0F returns err.
  - Other IDs return 0 and do not set err.
- When wr_en and rd_en are active in the same cycle, the read returns the pre-write value.
- Reset values:
  - Shadow and active sets for all channels: freq=FREQ_DEFAULT, phase=0, amp=0, wave=0, bias=0.
  - sel=0, auto=0, err=0, upd=0, rd_valid=0, rd_data=0.

## Timing
- Field write at edge N: shadow is visible at rd_data / internal state from edge N.
- With auto=1, active outputs change at edge N, and upd is high for cycle N..N+1 only.
- Commit write at edge N: all masked active outputs change at edge N together with upd.
- No output is combinationally dependent on the wr_* inputs.
- Readback: rd_en at edge N gives rd_valid=1 and rd_data valid during the cycle after N, for exactly one cycle. Back-to-back reads are allowed every cycle.
- A channel select write at edge N makes a field write at edge N+1 target the new channel.
- Reset asserted at any edge:
  - All state returns to the reset values at that edge.
  - A pending upd or rd_valid is cancelled.
  - Writes presented with rst_n=0 are discarded.

## Test plan
- Reset, then read 0x01 → rd_data=343597; all outputs at their defaults; upd=0; err=0.
- Write 0x05=1, then 0x01=1000, then 0x0B=0b10 → freq[63:32]=1000 at the commit edge with upd=0b10 for one cycle; freq[31:0] stays 343597 throughout.
- Write 0x0C=1, then 0x02=0x3FFF on channel 0 → phase[13:0]=0x3FFF and upd[0] pulse on the same edge. Write 0x02=0x1_FFFF → phase truncates to 0x3FFF.
- With NUM_CH=2, write 0x05=5 → sel stays at its prior value and err=1. Write 0x44 → err stays 1. Write 0x0F → err=0. Read 0x44 → rd_data=0 and err stays 0.
- Simultaneous write 0x04=7 and read 0x04 (prior value 3) → rd_data=3; the next read returns 7.
- Assert rst_n=0 for one cycle between a commit write and the following cycle → upd=0 and all active and shadow values at their defaults.
